uart_tx_arbiter: RTL and testbench

Shares the single UART transmit line of `Top` between `NUM_REQ` byte-stream requesters, such as CPU MMIO console writes and a debug/trace port. Requesters are served round-robin with message-level locking: once a requester wins, it keeps the line until it sends a byte flagged `last`. Bytes go out through an internal 8N1 serializer that drives `txd`.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_arbiter_if.sv | 12 +
 rtl/uart_tx_serializer.sv | 84 ++++++++
 rtl/uart_tx_arbiter.sv | 92 +++++++++
 tb/tb_uart_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and its serializer.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_t;
    typedef enum logic {UNLOCKED, LOCKED} arb_state_t;

    localparam int unsigned UART_BITS_PER_FRAME = 10;

    // Divider counter width; the counter runs 0..clk_div-1.
    function automatic int unsigned div_width(input int unsigned clk_div);
        return (clk_div > 2) ? $clog2(clk_div) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake bundle; NUM_REQ must match the arbiter instance.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;

    modport master (output req_valid, output req_data, output req_last, input req_ready);
    modport slave  (input req_valid, input req_data, input req_last, output req_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: latches a byte on load and shifts it out LSB first, CLK_DIV cycles per bit.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       idle,
    output logic       txd
);
    localparam int unsigned DivW     = div_width(CLK_DIV);
    localparam int unsigned DataBits = UART_BITS_PER_FRAME - 2;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [2:0]      LastIdx = 3'(DataBits - 1);

    ser_state_t      state;
    logic [DivW-1:0] div;
    logic [2:0]      idx;
    logic [7:0]      shreg;

    // txd is updated on the same edge as the state so it never lags a bit boundary.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            div   <= '0;
            idx   <= '0;
            shreg <= '0;
            txd   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load) begin
                        state <= START;
                        shreg <= data;
                        div   <= '0;
                        txd   <= 1'b0;
                    end
                end
                START: begin
                    if (div == DivLast) begin
                        state <= DATA;
                        div   <= '0;
                        idx   <= '0;
                        txd   <= shreg[0];
                    end else begin
                        div <= div + DivW'(1);
                    end
                end
                DATA: begin
                    if (div == DivLast) begin
                        div <= '0;
                        if (idx == LastIdx) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            idx <= idx + 3'd1;
                            txd <= shreg[idx + 3'd1];
                        end
                    end else begin
                        div <= div + DivW'(1);
                    end
                end
                STOP: begin
                    if (div == DivLast) begin
                        state <= IDLE;
                        div   <= '0;
                    end else begin
                        div <= div + DivW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

    assign idle = (state == IDLE);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one 8N1 UART transmit line between requesters.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned CLK_DIV = 16
) (
    input  logic              clock,
    input  logic              reset,
    uart_tx_arbiter_if.slave  req,
    output logic              txd,
    output logic              busy
);
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         arb_state;
    logic [IdxW-1:0]    owner;
    logic [IdxW-1:0]    rr;
    logic [NUM_REQ-1:0] grant;
    logic [IdxW-1:0]    grant_idx;
    logic [IdxW-1:0]    cand;
    logic               accept;
    logic               ser_idle;
    logic [7:0]         sel_data;
    logic               sel_last;

    // Scan downwards so the last hit, i.e. the one nearest rr+1, wins.
    always_comb begin
        grant     = '0;
        grant_idx = owner;
        cand      = '0;
        if (ser_idle) begin
            if (arb_state == LOCKED) begin
                grant[owner] = req.req_valid[owner];
            end else begin
                for (int k = NUM_REQ; k >= 1; k--) begin
                    cand = IdxW'((int'(rr) + k) % int'(NUM_REQ));
                    if (req.req_valid[cand]) begin
                        grant       = '0;
                        grant[cand] = 1'b1;
                        grant_idx   = cand;
                    end
                end
            end
        end
    end

    assign req.req_ready = grant;
    assign accept        = |grant;
    assign sel_data      = req.req_data[{grant_idx, 3'b000} +: 8];
    assign sel_last      = req.req_last[grant_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arb_state <= UNLOCKED;
            owner     <= '0;
            rr        <= IdxW'(NUM_REQ - 1);
        end else if (accept) begin
            unique case (arb_state)
                UNLOCKED: begin
                    if (sel_last) begin
                        rr <= grant_idx;
                    end else begin
                        arb_state <= LOCKED;
                        owner     <= grant_idx;
                    end
                end
                LOCKED: begin
                    if (sel_last) begin
                        arb_state <= UNLOCKED;
                        rr        <= owner;
                    end
                end
                default: arb_state <= UNLOCKED;
            endcase
        end
    end

    assign busy = !ser_idle || (arb_state == LOCKED);

    uart_tx_serializer #(
        .CLK_DIV (CLK_DIV)
    ) u_ser (
        .clock (clock),
        .reset (reset),
        .load  (accept),
        .data  (sel_data),
        .idle  (ser_idle),
        .txd   (txd)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a frame-level reference model checked every cycle, plus literal checks.
module tb_uart_tx_arbiter;
    localparam int D = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    uart_tx_arbiter_if #(.NUM_REQ(2)) bus2 ();
    uart_tx_arbiter_if #(.NUM_REQ(4)) bus4 ();
    logic txd2, busy2, txd4, busy4;

    uart_tx_arbiter #(.NUM_REQ(2), .CLK_DIV(D)) dut2 (
        .clock (clock), .reset (reset), .req (bus2), .txd (txd2), .busy (busy2)
    );
    uart_tx_arbiter #(.NUM_REQ(4), .CLK_DIV(D)) dut4 (
        .clock (clock), .reset (reset), .req (bus4), .txd (txd4), .busy (busy4)
    );

    // Per-requester drive state, index [dut][requester]; dut 0 has 2 requesters, dut 1 has 4.
    logic       drv_v [2][4];
    logic       drv_l [2][4];
    logic [7:0] drv_d [2][4];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            bus2.req_valid[i]       = drv_v[0][i];
            bus2.req_last[i]        = drv_l[0][i];
            bus2.req_data[8*i +: 8] = drv_d[0][i];
        end
        for (int i = 0; i < 4; i++) begin
            bus4.req_valid[i]       = drv_v[1][i];
            bus4.req_last[i]        = drv_l[1][i];
            bus4.req_data[8*i +: 8] = drv_d[1][i];
        end
    end

    logic [3:0] rdy [2];
    logic       txo [2];
    logic       bso [2];
    always_comb begin
        rdy[0] = {2'b00, bus2.req_ready};
        rdy[1] = bus4.req_ready;
        txo[0] = txd2;
        txo[1] = txd4;
        bso[0] = busy2;
        bso[1] = busy4;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: one frame in flight per DUT, described by its accept cycle and byte.
    typedef struct {
        int         d;
        int         i;
        logic [7:0] b;
    } gr_t;
    gr_t glog[$];

    int         nreq [2] = '{2, 4};
    int         t_fr [2];
    logic [7:0] fb   [2];
    bit         lk   [2];
    int         own  [2];
    int         rrm  [2];
    logic       txd_hist [0:4095];

    function automatic logic frame_bit(input int off, input logic [7:0] b);
        logic [7:0] s;
        if (off >= 1 && off <= D) return 1'b0;
        if (off > D && off <= 9 * D) begin
            s = b >> ((off - 1) / D - 1);
            return s[0];
        end
        return 1'b1;
    endfunction

    task automatic model_cycle(input int d);
        logic [3:0] er;
        bit         idle;
        int         off;
        int         gi;
        int         j;
        logic       ex_txd;
        string      sfx;
        sfx = (d == 0) ? "n2" : "n4";
        if (d == 0 && cyc < 4096) txd_hist[cyc] = txo[0];
        if (reset) begin
            t_fr[d] = -100000;
            lk[d]   = 1'b0;
            own[d]  = 0;
            rrm[d]  = nreq[d] - 1;
            check({"reset_txd_", sfx}, 32'(txo[d]), 32'd1);
            return;
        end
        off    = cyc - t_fr[d];
        idle   = (off > 10 * D);
        ex_txd = idle ? 1'b1 : frame_bit(off, fb[d]);
        er     = '0;
        gi     = -1;
        if (idle) begin
            if (lk[d]) begin
                if (drv_v[d][own[d]]) begin
                    er = 4'b1 << own[d];
                    gi = own[d];
                end
            end else begin
                for (int k = 1; k <= nreq[d]; k++) begin
                    j = (rrm[d] + k) % nreq[d];
                    if (drv_v[d][j]) begin
                        er = 4'b1 << j;
                        gi = j;
                        break;
                    end
                end
            end
        end
        check({"ready_", sfx}, 32'(rdy[d]), 32'(er));
        check({"txd_", sfx}, 32'(txo[d]), 32'(ex_txd));
        check({"busy_", sfx}, 32'(bso[d]), 32'(!idle || lk[d]));
        if (gi >= 0) begin
            glog.push_back('{d, gi, drv_d[d][gi]});
            t_fr[d] = cyc;
            fb[d]   = drv_d[d][gi];
            if (!lk[d]) begin
                if (drv_l[d][gi]) rrm[d] = gi;
                else begin
                    lk[d]  = 1'b1;
                    own[d] = gi;
                end
            end else if (drv_l[d][gi]) begin
                lk[d]  = 1'b0;
                rrm[d] = own[d];
            end
        end
    endtask

    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) model_cycle(d);
    end

    task automatic send(input int d, input int i, input logic [7:0] b, input logic l,
                        output int t_acc);
        bit got;
        got   = 1'b0;
        t_acc = -1;
        drv_d[d][i] = b;
        drv_l[d][i] = l;
        drv_v[d][i] = 1'b1;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clock);
            if (((rdy[d] >> i) & 4'd1) != 4'd0) begin
                got   = 1'b1;
                t_acc = cyc;
            end
            @(posedge clock);
            #1;
        end
        drv_v[d][i] = 1'b0;
        if (!got) check("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ta, tb2, tc, t1, t2, t5, g0, tx, ty;
        logic [9:0] seq;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) begin
                drv_v[d][i] = 1'b0;
                drv_l[d][i] = 1'b0;
                drv_d[d][i] = 8'h00;
            end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Idle line after reset.
        repeat (100) @(posedge clock);
        #1;
        check("idle_txd", 32'(txd2), 32'd1);
        check("idle_busy", 32'(busy2), 32'd0);
        check("idle_ready", 32'(bus2.req_ready), 32'd0);

        // Locked two-byte message from req0 while req1 waits.
        g0 = glog.size();
        fork
            begin
                send(0, 0, 8'h41, 1'b0, ta);
                send(0, 0, 8'h42, 1'b1, tb2);
            end
            send(0, 1, 8'h43, 1'b1, tc);
        join
        check("ab_period", 32'(tb2 - ta), 32'd41);
        check("c_after_b", 32'(tc - tb2), 32'd41);
        check("ab_count", 32'(glog.size() - g0), 32'd3);
        if (glog.size() - g0 == 3) begin
            check("ab_b0", 32'(glog[g0].b), 32'h41);
            check("ab_b1", 32'(glog[g0+1].b), 32'h42);
            check("ab_b2", 32'(glog[g0+2].b), 32'h43);
            check("ab_i2", 32'(glog[g0+2].i), 32'd1);
        end

        // 0x55 frame shape and back-to-back period.
        send(0, 0, 8'h55, 1'b1, t1);
        send(0, 0, 8'h0F, 1'b1, t2);
        check("b2b_period", 32'(t2 - t1), 32'd41);
        for (int k = 0; k < 10; k++) seq[k] = txd_hist[t1 + 1 + k * D];
        check("frame_55", 32'(seq), 32'h2AA);
        check("start_last", 32'(txd_hist[t1 + D]), 32'd0);
        check("idle_gap", 32'(txd_hist[t2]), 32'd1);

        // Both requesters stream single-byte messages; rr is 0 here so req1 leads.
        g0 = glog.size();
        fork
            for (int k = 0; k < 4; k++) send(0, 0, 8'(8'hA0 + k), 1'b1, tx);
            for (int k = 0; k < 4; k++) send(0, 1, 8'(8'hB0 + k), 1'b1, ty);
        join
        check("alt_count", 32'(glog.size() - g0), 32'd8);
        if (glog.size() - g0 == 8)
            for (int k = 0; k < 8; k++) check("alt_owner", 32'(glog[g0+k].i), 32'((k + 1) % 2));

        // Reset during data bit 3 of a locked message.
        send(0, 0, 8'h77, 1'b0, t5);
        for (int n = 0; n < 200 && cyc < t5 + 18; n++) begin
            @(posedge clock);
            #1;
        end
        #1;
        check("pre_reset_txd", 32'(txd2), 32'd0);
        check("pre_reset_busy", 32'(busy2), 32'd1);
        reset = 1'b1;
        #1;
        check("async_txd", 32'(txd2), 32'd1);
        check("async_busy", 32'(busy2), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("post_reset_busy", 32'(busy2), 32'd0);
        g0 = glog.size();
        fork
            send(0, 1, 8'h21, 1'b1, tx);
            send(0, 0, 8'h20, 1'b1, ty);
        join
        check("post_reset_count", 32'(glog.size() - g0), 32'd2);
        if (glog.size() - g0 == 2) begin
            check("post_reset_first", 32'(glog[g0].i), 32'd0);
            check("post_reset_second", 32'(glog[g0+1].i), 32'd1);
        end

        // Four requesters: rr=1 with requests on 1 and 3.
        send(1, 1, 8'h10, 1'b1, tx);
        g0 = glog.size();
        fork
            send(1, 1, 8'h11, 1'b1, tx);
            send(1, 3, 8'h33, 1'b1, ty);
        join
        check("n4_count", 32'(glog.size() - g0), 32'd2);
        if (glog.size() - g0 == 2) begin
            check("n4_first", 32'(glog[g0].i), 32'd3);
            check("n4_second", 32'(glog[g0+1].i), 32'd1);
        end

        repeat (50) @(posedge clock);
        #1;
        check("end_txd4", 32'(txd4), 32'd1);
        check("end_busy4", 32'(busy4), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
